// File: rtl/pll_rst_seq_if.sv
// Lock inputs and reset/status outputs of the two-PLL reset sequencer.
// Optional relock_cnt_o is present only when PLL_SEQ_RELOCK_CNT_EN is defined.
interface pll_rst_seq_if;
    logic       lock_rtc_i;
    logic       lock_sys_i;
    logic       pll_rtc_rst_o;
    logic       pll_sys_rst_o;
    logic       core_rst_o;
    logic       seq_done_o;
    logic       seq_fail_o;
    logic [2:0] state_o;
`ifdef PLL_SEQ_RELOCK_CNT_EN
    logic [7:0] relock_cnt_o;
`endif

    modport slave (
        input  lock_rtc_i, lock_sys_i,
`ifdef PLL_SEQ_RELOCK_CNT_EN
        output relock_cnt_o,
`endif
        output pll_rtc_rst_o, pll_sys_rst_o, core_rst_o, seq_done_o, seq_fail_o, state_o
    );

    modport master (
        output lock_rtc_i, lock_sys_i,
`ifdef PLL_SEQ_RELOCK_CNT_EN
        input  relock_cnt_o,
`endif
        input  pll_rtc_rst_o, pll_sys_rst_o, core_rst_o, seq_done_o, seq_fail_o, state_o
    );
endinterface

// File: rtl/pll_rst_seq.sv
// Power-on/relock sequencer: RTC PLL, then system PLL, then core reset release.
// Define PLL_SEQ_RELOCK_CNT_EN to add the saturating relock_cnt_o counter.
//
// state      | meaning
// S_RTC_RST  | both PLL resets held for RST_HOLD_CYC
// S_RTC_WAIT | RTC PLL released, waiting for stable lock or timeout
// S_SYS_RST  | system PLL reset held for RST_HOLD_CYC
// S_SYS_WAIT | system PLL released, waiting for stable lock or timeout
// S_CORE_DLY | both PLLs stable, core reset held for CORE_RST_DLY
// S_RUN      | core released, locks monitored
// S_FAIL     | retries exhausted, everything held in reset until rst
module pll_rst_seq #(
    parameter int RST_HOLD_CYC     = 16,
    parameter int LOCK_STABLE_CYC  = 64,
    parameter int LOCK_TIMEOUT_CYC = 65535,
    parameter int MAX_RETRY        = 3,
    parameter int CORE_RST_DLY     = 256,
    parameter int CNT_W            = 16
) (
    input logic          clkin,
    input logic          reset,
    pll_rst_seq_if.slave bus
);
    localparam logic [2:0] S_RTC_RST  = 3'd0;
    localparam logic [2:0] S_RTC_WAIT = 3'd1;
    localparam logic [2:0] S_SYS_RST  = 3'd2;
    localparam logic [2:0] S_SYS_WAIT = 3'd3;
    localparam logic [2:0] S_CORE_DLY = 3'd4;
    localparam logic [2:0] S_RUN      = 3'd5;
    localparam logic [2:0] S_FAIL     = 3'd6;

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]   CNT_MAX      = '1;
    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]   CORE_LAST    = CNT_W'(CORE_RST_DLY - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRY);

    logic [1:0]         lr_sync_q, ls_sync_q;
    logic               lr, ls;
    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0]   stab_q, stab_d, stab_inc;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               timeout;
    logic               pll_rtc_rst_q, pll_sys_rst_q, core_rst_q, seq_done_q, seq_fail_q;

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lr_sync_q <= 2'b00;
            ls_sync_q <= 2'b00;
        end else begin
            lr_sync_q <= {lr_sync_q[0], bus.lock_rtc_i};
            ls_sync_q <= {ls_sync_q[0], bus.lock_sys_i};
        end
    end

    assign lr = lr_sync_q[1];
    assign ls = ls_sync_q[1];

    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign stab_inc = (stab_q == CNT_MAX) ? stab_q : stab_q + CNT_W'(1);
    assign timeout  = (cnt_q == TIMEOUT_LAST);

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        stab_d  = '0;
        case (state_q)
            S_RTC_RST: begin
                if (cnt_q == HOLD_LAST) state_d = S_RTC_WAIT;
            end
            S_RTC_WAIT: begin
                stab_d = lr ? stab_inc : '0;
                if (timeout) begin
                    if (retry_q == RETRY_LAST) begin
                        state_d = S_FAIL;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = S_RTC_RST;
                    end
                end else if (lr && stab_q == STABLE_LAST) begin
                    state_d = S_SYS_RST;
                end
            end
            S_SYS_RST: begin
                if (!lr) state_d = S_RTC_RST;
                else if (cnt_q == HOLD_LAST) state_d = S_SYS_WAIT;
            end
            S_SYS_WAIT: begin
                stab_d = ls ? stab_inc : '0;
                if (timeout) begin
                    if (retry_q == RETRY_LAST) begin
                        state_d = S_FAIL;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = S_RTC_RST;
                    end
                end else if (!lr) begin
                    state_d = S_RTC_RST;
                end else if (ls && stab_q == STABLE_LAST) begin
                    state_d = S_CORE_DLY;
                end
            end
            S_CORE_DLY: begin
                if (!lr) state_d = S_RTC_RST;
                else if (!ls) state_d = S_SYS_RST;
                else if (cnt_q == CORE_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                if (!lr) state_d = S_RTC_RST;
                else if (!ls) state_d = S_SYS_RST;
            end
            S_FAIL: state_d = S_FAIL;
            default: state_d = S_RTC_RST;
        endcase

        if (state_d == S_RUN && state_q != S_RUN) retry_d = '0;

        // Shared cycle counter and stable counter both restart on any state change.
        if (state_d != state_q) begin
            cnt_d  = '0;
            stab_d = '0;
        end else begin
            cnt_d  = cnt_inc;
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q       <= S_RTC_RST;
            cnt_q         <= '0;
            stab_q        <= '0;
            retry_q       <= '0;
            pll_rtc_rst_q <= 1'b1;
            pll_sys_rst_q <= 1'b1;
            core_rst_q    <= 1'b1;
            seq_done_q    <= 1'b0;
            seq_fail_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stab_q        <= stab_d;
            retry_q       <= retry_d;
            pll_rtc_rst_q <= (state_d == S_RTC_RST) || (state_d == S_FAIL);
            pll_sys_rst_q <= (state_d == S_RTC_RST) || (state_d == S_RTC_WAIT) ||
                             (state_d == S_SYS_RST) || (state_d == S_FAIL);
            core_rst_q    <= (state_d != S_RUN);
            seq_done_q    <= (state_d == S_RUN);
            seq_fail_q    <= seq_fail_q || (state_d == S_FAIL);
        end
    end

`ifdef PLL_SEQ_RELOCK_CNT_EN
    logic       relock_ev;
    logic [7:0] relock_q;

    assign relock_ev = (state_q == S_RUN) && (!lr || !ls);

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) relock_q <= 8'd0;
        else if (relock_ev && relock_q != 8'hFF) relock_q <= relock_q + 8'd1;
    end

    assign bus.relock_cnt_o = relock_q;
`endif

    assign bus.pll_rtc_rst_o = pll_rtc_rst_q;
    assign bus.pll_sys_rst_o = pll_sys_rst_q;
    assign bus.core_rst_o    = core_rst_q;
    assign bus.seq_done_o    = seq_done_q;
    assign bus.seq_fail_o    = seq_fail_q;
    assign bus.state_o       = state_q;
endmodule
